// File: rtl/tanh4_rr_scheduler.sv
// tanh4_rr_scheduler: round-robin sharing of one 4-bit approximate tanh core among NREQ lanes.
// Define TANH4_SCHED_IN_REG_EN to add an input register stage ahead of the core (latency 2).
module tanh4_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int TW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [4*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              out_valid,
    output logic [3:0]        out_data,
    output logic [TW-1:0]     out_tag,
    input  logic              out_ready,
    input  logic              flush,
    output logic              busy
);
    localparam int            DATA_W   = 4;
    localparam logic [TW:0]   NREQ_W   = (TW+1)'(NREQ);
    localparam logic [TW-1:0] LAST_IDX = TW'(NREQ - 1);

    function automatic logic [DATA_W-1:0] tanh4(input logic [DATA_W-1:0] i);
        logic x;
        logic n4;
        x  = i[0] ^ i[1];
        n4 = ~(~(i[3] | ~(i[0] | i[2])) | x);
        return {~(i[0] ^ n4), (n4 | i[1]) & (x | i[2]), i[0], i[0]};
    endfunction

    logic [TW-1:0]     ptr;
    logic [TW-1:0]     ptr_nxt;
    logic              accept;
    logic              grant_any;
    logic              grant_fire;
    logic [TW-1:0]     grant_idx;
    logic [DATA_W-1:0] grant_data;
    logic [TW:0]       cand;

    logic              vld_p2;
    logic [DATA_W-1:0] data_p2;
    logic [TW-1:0]     tag_p2;
    logic              s2_load;
    logic              s2_vld_in;
    logic [DATA_W-1:0] s2_data_in;
    logic [TW-1:0]     s2_tag_in;

    // Cyclic scan starting at ptr; the first valid lane wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (TW+1)'(k);
            if (cand >= NREQ_W) cand = cand - NREQ_W;
            if (!grant_any && req_valid[cand[TW-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[TW-1:0];
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == TW'(i)) grant_data = req_data[DATA_W*i +: DATA_W];
        end
    end

    assign grant_fire = grant_any & accept & ~flush & rst_n;
    assign req_ready  = grant_fire ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_idx) : '0;
    assign ptr_nxt    = (grant_idx == LAST_IDX) ? '0 : grant_idx + TW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          ptr <= '0;
        else if (flush)      ptr <= '0;
        else if (grant_fire) ptr <= ptr_nxt;
    end

    assign s2_load = ~vld_p2 | out_ready;

`ifdef TANH4_SCHED_IN_REG_EN
    logic              vld_p1;
    logic [DATA_W-1:0] raw_p1;
    logic [TW-1:0]     tag_p1;

    assign accept = ~vld_p1 | s2_load;

    // Stage 1: registered raw operand and tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            raw_p1 <= '0;
            tag_p1 <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1 <= grant_fire;
            if (grant_fire) begin
                raw_p1 <= grant_data;
                tag_p1 <= grant_idx;
            end
        end
    end

    assign s2_vld_in  = vld_p1;
    assign s2_data_in = tanh4(raw_p1);
    assign s2_tag_in  = tag_p1;
    assign busy       = vld_p1 | vld_p2;
`else
    assign accept     = s2_load;
    assign s2_vld_in  = grant_fire;
    assign s2_data_in = tanh4(grant_data);
    assign s2_tag_in  = grant_idx;
    assign busy       = vld_p2;
`endif

    // Stage 2: core result and tag, held stable under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            data_p2 <= '0;
            tag_p2  <= '0;
        end else if (flush) begin
            vld_p2 <= 1'b0;
        end else if (s2_load) begin
            vld_p2 <= s2_vld_in;
            if (s2_vld_in) begin
                data_p2 <= s2_data_in;
                tag_p2  <= s2_tag_in;
            end
        end
    end

    assign out_valid = vld_p2;
    assign out_data  = data_p2;
    assign out_tag   = tag_p2;

endmodule

// File: tb/tb_tanh4_rr_scheduler.sv
// Scoreboard bench for tanh4_rr_scheduler (default build, single output stage).
`timescale 1ns/1ps
module tb_tanh4_rr_scheduler;
    localparam int NREQ = 4;
    localparam int TW   = $clog2(NREQ);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid;
    logic [4*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              out_valid;
    logic [3:0]        out_data;
    logic [TW-1:0]     out_tag;
    logic              out_ready;
    logic              flush;
    logic              busy;

    always #5 clk = ~clk;

    tanh4_rr_scheduler #(.NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
        .out_tag(out_tag), .out_ready(out_ready), .flush(flush), .busy(busy)
    );

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [3:0]    data;
    } item_t;

    item_t sb_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_tanh(input logic [3:0] a);
        bit x;
        bit n4;
        x  = a[0] ^ a[1];
        n4 = !(!(a[3] || !(a[0] || a[2])) || x);
        return {!(a[0] ^ n4), (n4 || a[1]) && (x || a[2]), a[0], a[0]};
    endfunction

    // Reference model: who should be granted this cycle, and what result that produces.
    int              m_ptr;
    bit              m_occ;
    bit              m_acc;
    int              m_g;
    logic [NREQ-1:0] m_rdy;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_ptr = 0;
            m_occ = 0;
            check("ready_in_reset", req_ready, 0);
        end else begin
            m_rdy = '0;
            m_g   = -1;
            m_acc = !m_occ || out_ready;
            if (m_acc && !flush) begin
                for (int k = 0; k < NREQ; k++)
                    if (m_g < 0 && req_valid[(m_ptr + k) % NREQ]) m_g = (m_ptr + k) % NREQ;
            end
            if (m_g >= 0) m_rdy[m_g] = 1'b1;
            check("req_ready", req_ready, m_rdy);
            check("out_valid", out_valid, m_occ);
            check("busy", busy, m_occ);
            if (flush) begin
                m_ptr = 0;
                m_occ = 0;
            end else if (m_g >= 0) begin
                sb_q.push_back({TW'(m_g), ref_tanh(req_data[4*m_g +: 4])});
                m_ptr = (m_g + 1) % NREQ;
                m_occ = 1;
            end else if (out_ready) begin
                m_occ = 0;
            end
        end
    end

    // Monitor: pop and compare on every delivered result, and watch stability under stall.
    item_t      exp_it;
    bit         stall_prev = 0;
    logic [3:0] prev_data;
    logic [TW-1:0] prev_tag;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            stall_prev = 0;
        end else begin
            if (out_valid && stall_prev) begin
                check("stall_data", out_data, prev_data);
                check("stall_tag", out_tag, prev_tag);
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got tag %0d data %0h, expected none", out_tag, out_data);
                end else begin
                    exp_it = sb_q.pop_front();
                    check("out_data", out_data, exp_it.data);
                    check("out_tag", out_tag, exp_it.tag);
                end
            end
            if (flush) sb_q.delete();
            stall_prev = out_valid && !out_ready && !flush;
            prev_data  = out_data;
            prev_tag   = out_tag;
        end
    end

    logic [NREQ-1:0] hs;

    task automatic step();
        @(negedge clk);
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
    endtask

    // Lanes that were granted or idle may change; pending lanes keep their operand.
    task automatic lanes(input int pct);
        for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] || hs[i]) begin
                req_valid[i]       = ($urandom_range(99) < pct);
                req_data[4*i +: 4] = 4'($urandom);
            end
        end
    endtask

    logic [3:0] sweep_op  [5] = '{4'h0, 4'h3, 4'h6, 4'h9, 4'hF};
    logic [3:0] sweep_exp [5] = '{4'h0, 4'h3, 4'hC, 4'h3, 4'hF};

    initial begin
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b1;
        flush     = 1'b0;
        hs        = '0;
        @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single request on lane 1
        req_valid = 4'b0010;
        req_data  = 16'h0050;
        step();
        req_valid = '0;
        check("first_valid", out_valid, 1);
        check("first_data", out_data, 4'h3);
        check("first_tag", out_tag, 1);
        step();

        // Operand sweep on lane 0
        for (int j = 0; j < 5; j++) begin
            req_valid = 4'b0001;
            req_data  = {12'h000, sweep_op[j]};
            step();
            check("sweep_data", out_data, sweep_exp[j]);
        end
        req_valid = '0;
        step();

        // All lanes valid, full throughput
        lanes(100);
        repeat (8) begin
            step();
            lanes(100);
        end

        // Backpressure
        out_ready = 1'b0;
        repeat (5) begin
            step();
            lanes(100);
        end
        out_ready = 1'b1;
        repeat (4) begin
            step();
            lanes(100);
        end

        // Flush with a full pipeline and a stalled output
        out_ready = 1'b0;
        step();
        lanes(100);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_out_valid", out_valid, 0);
        check("flush_busy", busy, 0);
        out_ready = 1'b1;
        repeat (3) begin
            step();
            lanes(100);
        end

        // Randomized traffic with occasional flush and stalls
        repeat (400) begin
            out_ready = ($urandom_range(99) < 75);
            flush     = ($urandom_range(99) < 3);
            lanes(60);
            step();
        end
        flush     = 1'b0;
        out_ready = 1'b1;

        // Asynchronous reset mid-stream
        repeat (3) begin
            lanes(100);
            step();
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        check("arst_out_tag", out_tag, 0);
        check("arst_busy", busy, 0);
        check("arst_req_ready", req_ready, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (50) begin
            out_ready = ($urandom_range(99) < 80);
            lanes(70);
            step();
        end

        // Drain
        req_valid = '0;
        out_ready = 1'b1;
        repeat (4) step();
        check("sb_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
